// File: rtl/qtps_issue_queue.sv
// qtps_issue_queue
//   Instruction issue queue that sits between an upstream fetch stage and the
//   core. Instructions are stored in a circular FIFO. When the core flags the
//   last issued instruction as illegal, the queue flushes and halts. It blames
//   the most recently popped instruction and counts the event in a saturating
//   counter. A resume request leaves the halted state with an empty queue.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   s_valid      : upstream instruction valid
//   s_ready      : queue can accept an instruction
//   s_instr      : upstream instruction
//   m_valid      : head instruction offered to the core
//   m_ready      : core accepts the head instruction
//   m_instr      : head-of-queue instruction
//   core_illegal : core flags the last issued instruction as illegal
//   resume       : request to leave the halted state
//   level        : current occupancy
//   halted       : queue is in the halted state
//   fault_instr  : instruction blamed for the last illegal event
//   illegal_cnt  : saturating count of illegal events
module qtps_issue_queue #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_instr,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [INSTR_W-1:0] m_instr,
  input  logic               core_illegal,
  input  logic               resume,
  output logic [CNT_W-1:0]   level,
  output logic               halted,
  output logic [INSTR_W-1:0] fault_instr,
  output logic [15:0]        illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [INSTR_W-1:0] last_issued_q, last_issued_d;
  logic [INSTR_W-1:0] fault_instr_q, fault_instr_d;
  logic [15:0]        illegal_cnt_q, illegal_cnt_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic in_run;
  logic push;
  logic pop;

  // Handshakes are gated by reset and by core_illegal so nothing transfers
  // in a flush cycle.
  assign in_run  = rst_n && (state_q == ST_RUN) && !core_illegal;
  assign s_ready = in_run && (level_q < CNT_W'(DEPTH));
  assign m_valid = in_run && (level_q != '0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign m_instr     = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign halted      = (state_q == ST_HALT);
  assign fault_instr = fault_instr_q;
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    last_issued_d = last_issued_q;
    fault_instr_d = fault_instr_q;
    illegal_cnt_d = illegal_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (core_illegal) begin
          state_d       = ST_HALT;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          level_d       = '0;
          fault_instr_d = last_issued_q;
          if (illegal_cnt_q != '1) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
          end
        end else begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            last_issued_d = mem_q[rd_ptr_q];
          end
          if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
          end else if (pop && !push) begin
            level_d = level_q - CNT_W'(1);
          end
        end
      end
      default: begin
        if (resume) begin
          state_d  = ST_RUN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      last_issued_q <= '0;
      fault_instr_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      last_issued_q <= last_issued_d;
      fault_instr_q <= fault_instr_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage carries no reset; push already implies rst_n=1.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_instr;
    end
  end

endmodule

// File: tb/tb_qtps_issue_queue.sv
module tb_qtps_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n, s_valid, s_ready, m_valid, m_ready, core_illegal, resume, halted;
  logic [31:0] s_instr, m_instr, fault_instr;
  logic [3:0]  level;
  logic [15:0] illegal_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  qtps_issue_queue #(.INSTR_W(32), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_instr(s_instr),
    .m_valid(m_valid), .m_ready(m_ready), .m_instr(m_instr),
    .core_illegal(core_illegal), .resume(resume),
    .level(level), .halted(halted),
    .fault_instr(fault_instr), .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic        rst_n, sv;
    logic [31:0] instr;
    logic        mr, ill, res;
    logic        e_sr, e_mv;
    logic [31:0] e_mi;
    logic [3:0]  e_lvl;
    logic        e_halt;
    logic [31:0] e_fault;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic sv, input logic [31:0] ins,
                     input logic mr, input logic ill, input logic res,
                     input logic sr, input logic mv, input logic [31:0] mi,
                     input logic [3:0] lvl, input logic h,
                     input logic [31:0] f, input logic [15:0] c);
    vec_t v;
    v.rst_n = r; v.sv = sv; v.instr = ins; v.mr = mr; v.ill = ill; v.res = res;
    v.e_sr = sr; v.e_mv = mv; v.e_mi = mi; v.e_lvl = lvl; v.e_halt = h;
    v.e_fault = f; v.e_cnt = c;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [31:0] ins,
                       input logic mr, input logic ill, input logic res);
    @(negedge clk);
    rst_n = r; s_valid = sv; s_instr = ins; m_ready = mr;
    core_illegal = ill; resume = res;
  endtask

  task automatic step(input logic r, input logic sv, input logic [31:0] ins,
                      input logic mr, input logic ill, input logic res);
    drive(r, sv, ins, mr, ill, res);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_instr = '0; m_ready = 1'b0;
    core_illegal = 1'b0; resume = 1'b0;

    // reset with push requested: reset wins
    add(0, 1, 32'hDEAD, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    // fill 1..8, then push at full is refused
    for (int k = 1; k <= 8; k++)
      add(1, 1, k, 0, 0, 0,  1, (k > 1), 1,  4'(k), 0, 0, 0);
    add(1, 1, 9, 0, 0, 0,  0, 1, 1,  8, 0, 0, 0);
    // drain in order
    for (int k = 1; k <= 8; k++)
      add(1, 0, 0, 1, 0, 0,  (k > 1), 1, k,  4'(8 - k), 0, 0, 0);
    add(1, 0, 0, 1, 0, 0,  1, 0, 0,  0, 0, 0, 0);
    // advance both pointers to 5
    for (int k = 0; k < 5; k++)
      add(1, 1, 32'h20 + k, 0, 0, 0,  1, (k > 0), 32'h20,  4'(k + 1), 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(1, 0, 0, 1, 0, 0,  1, 1, 32'h20 + k,  4'(4 - k), 0, 0, 0);
    // level 3, then concurrent push/pop across the pointer wrap
    for (int k = 0; k < 3; k++)
      add(1, 1, 32'h11 + k, 0, 0, 0,  1, (k > 0), 32'h11,  4'(k + 1), 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(1, 1, 32'h14 + k, 1, 0, 0,  1, 1, 32'h11 + k,  3, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 1, 0, 0,  1, 1, 32'h15 + k,  4'(2 - k), 0, 0, 0);
    // illegal event blames the last popped instruction
    add(1, 1, 32'hA, 0, 0, 0,  1, 0, 0,      1, 0, 0, 0);
    add(1, 1, 32'hB, 0, 0, 0,  1, 1, 32'hA,  2, 0, 0, 0);
    add(1, 0, 0,     1, 0, 0,  1, 1, 32'hA,  1, 0, 0, 0);
    add(1, 1, 32'hC, 1, 1, 0,  0, 0, 0,      0, 1, 32'hA, 1);
    // illegal ignored in HALT, then resume
    add(1, 1, 32'hD, 1, 1, 0,  0, 0, 0,      0, 1, 32'hA, 1);
    add(1, 1, 32'hE, 1, 0, 1,  0, 0, 0,      0, 0, 32'hA, 1);
    // resume ignored in RUN
    add(1, 1, 32'h40, 0, 0, 1, 1, 0, 0,      1, 0, 32'hA, 1);
    add(1, 0, 0,      1, 0, 0, 1, 1, 32'h40, 0, 0, 32'hA, 1);
    // mid-operation reset at level 5
    for (int k = 0; k < 5; k++)
      add(1, 1, 32'h31 + k, 0, 0, 0,  1, (k > 0), 32'h31,  4'(k + 1), 0, 32'hA, 1);
    add(0, 1, 32'h36, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0,      0, 0, 0,  1, 0, 0,  0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].sv, vq[i].instr, vq[i].mr, vq[i].ill, vq[i].res);
      #1;
      check("s_ready", i, 32'(s_ready), 32'(vq[i].e_sr));
      check("m_valid", i, 32'(m_valid), 32'(vq[i].e_mv));
      if (vq[i].e_mv) check("m_instr", i, m_instr, vq[i].e_mi);
      @(posedge clk);
      #1;
      check("level",       i, 32'(level),       32'(vq[i].e_lvl));
      check("halted",      i, 32'(halted),      32'(vq[i].e_halt));
      check("fault_instr", i, fault_instr,      vq[i].e_fault);
      check("illegal_cnt", i, 32'(illegal_cnt), 32'(vq[i].e_cnt));
    end

    // Saturation: last_issued was cleared by the reset above, so blame is 0.
    step(1, 0, 0, 0, 1, 0);
    check("sat_halt",  100, 32'(halted), 1);
    check("sat_fault", 100, fault_instr, 0);
    check("sat_cnt1",  100, 32'(illegal_cnt), 1);
    // Preload the counter near its limit instead of 65k illegal/resume rounds.
    force dut.illegal_cnt_q = 16'hFFFD;
    step(1, 0, 0, 0, 0, 0);
    release dut.illegal_cnt_q;
    step(1, 0, 0, 0, 0, 0);
    check("sat_pre", 101, 32'(illegal_cnt), 32'hFFFD);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1);
      check("sat_resume", 102 + k, 32'(halted), 0);
      step(1, 0, 0, 0, 1, 0);
      check("sat_cnt", 102 + k, 32'(illegal_cnt), (k == 0) ? 32'hFFFE : 32'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
